alu_seq_exec: RTL and testbench

- Multi-cycle execute unit. It consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and returns the result and a zero flag.
- It sits between the decode/operand stage and writeback, with valid/ready handshakes on both sides.
- Logic and arithmetic ops finish in one cycle. Shifts run iteratively, one bit per cycle, to save area; an optional barrel shifter makes them single-cycle.

---
 rtl/alu_seq_exec.sv | 138 +++++++++++++
 tb/tb_alu_seq_exec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit: single-cycle logic/arithmetic, iterative one-bit-per-cycle shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [3:0]         ctrl_q;
    logic [SHW-1:0]     count;
    logic [SHW-1:0]     amt;
    logic [XLEN-1:0]    alu_res;
    logic               alu_illegal;
    logic               is_shift;
    logic [XLEN-1:0]    shift_next;

    function automatic logic [XLEN-1:0] shift1(input logic [3:0] ctrl, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (ctrl)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[XLEN-1:1]};
            default: r = {v[XLEN-1], v[XLEN-1:1]};
        endcase
        return r;
    endfunction

    assign in_ready   = rst_n && (state == IDLE);
    assign amt        = op_b[SHW-1:0];
    assign is_shift   = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign shift_next = shift1(ctrl_q, result);

    // Single-cycle datapath; in the iterative build it only resolves shifts of 0 or 1.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res = op_a << amt;
            OP_SRL:  alu_res = op_a >> amt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> amt);
`else
            OP_SLL, OP_SRL, OP_SRA:
                     alu_res = (amt == '0) ? op_a : shift1(alu_ctrl, op_a);
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    // The first shift step happens on the accepting edge, so an n-bit shift reports after n cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ctrl_q    <= '0;
            count     <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_q <= alu_ctrl;
`ifndef ALU_FAST_SHIFT_EN
                        if (is_shift && (amt > SHW'(1))) begin
                            result <= shift1(alu_ctrl, op_a);
                            count  <= amt - SHW'(1);
                            state  <= SHIFT;
                        end else
`endif
                        begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= alu_illegal;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    result <= shift_next;
                    count  <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        zero      <= (shift_next == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed corner cases plus randomized ops against a reference model.
module tb_alu_seq_exec;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      alu_ctrl = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int nvec = 0;
    int nerr = 0;

    alu_seq_exec #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference model straight from the code table.
    function automatic logic [XLEN-1:0] ref_result(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n;
        n = int'(b[SHW-1:0]);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return a ^ b;
            4'b0011: return a << n;
            4'b1000: return a >> n;
            4'b1010: return $unsigned($signed(a) >>> n);
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: return (a < b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [3:0] c);
        return !(c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                           4'b0011, 4'b1000, 4'b1010, 4'b0100, 4'b0101});
    endfunction

    function automatic int ref_latency(input logic [3:0] c, input logic [XLEN-1:0] b);
        int n;
        n = int'(b[SHW-1:0]);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if (c inside {4'b0011, 4'b1000, 4'b1010})
            return (n > 1) ? n : 1;
        return 1;
`endif
    endfunction

    // Drives one request, scrambles inputs after acceptance, measures latency, then drains the result.
    task automatic do_op(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         output logic [XLEN-1:0] res, output logic z, output logic ill, output int lat);
        @(negedge clk);
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result; z = zero; ill = illegal;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd3; op_b = 32'd4;
        repeat (3) @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL reset_in_ready_low got %b want 0", in_ready); end
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        in_valid = 1'b0; rst_n = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        nvec++;
        if ({result, zero, illegal} !== {32'h0, 1'b0, 1'b0}) begin
            nerr++; $display("[TB] FAIL reset_outputs got result=%h zero=%b illegal=%b want 0/0/0", result, zero, illegal);
        end
    endtask

    task automatic test_add_sub;
        logic [XLEN-1:0] r; logic z, il; int lat;
        do_op(4'b0010, 32'hFFFF_FFFF, 32'h1, r, z, il, lat);
        nvec++;
        if ({r, z, il} !== {32'h0, 1'b1, 1'b0}) begin nerr++; $display("[TB] FAIL add_wrap got %h z=%b il=%b want 0 z=1 il=0", r, z, il); end
        nvec++;
        if (lat !== 1) begin nerr++; $display("[TB] FAIL add_latency got %0d want 1", lat); end
        do_op(4'b0110, 32'd5, 32'd7, r, z, il, lat);
        nvec++;
        if ({r, z} !== {32'hFFFF_FFFE, 1'b0}) begin nerr++; $display("[TB] FAIL sub_wrap got %h z=%b want fffffffe z=0", r, z); end
    endtask

    task automatic test_shifts;
        logic [XLEN-1:0] r; logic z, il; int lat;
        do_op(4'b1010, 32'h8000_0000, 32'h4, r, z, il, lat);
        nvec++;
        if (r !== 32'hF800_0000) begin nerr++; $display("[TB] FAIL sra4 got %h want f8000000", r); end
        nvec++;
        if (lat !== ref_latency(4'b1010, 32'h4)) begin nerr++; $display("[TB] FAIL sra4_latency got %0d want %0d", lat, ref_latency(4'b1010, 32'h4)); end
        do_op(4'b1000, 32'h8000_0000, 32'h4, r, z, il, lat);
        nvec++;
        if (r !== 32'h0800_0000) begin nerr++; $display("[TB] FAIL srl4 got %h want 08000000", r); end
        do_op(4'b0011, 32'h1234_5678, 32'h20, r, z, il, lat);
        nvec++;
        if ({r, lat} !== {32'h1234_5678, 32'd1}) begin nerr++; $display("[TB] FAIL sll_amt0 got %h lat=%0d want 12345678 lat=1", r, lat); end
        do_op(4'b0011, 32'h1, 32'd31, r, z, il, lat);
        nvec++;
        if (r !== 32'h8000_0000) begin nerr++; $display("[TB] FAIL sll31 got %h want 80000000", r); end
        nvec++;
        if (lat !== ref_latency(4'b0011, 32'd31)) begin nerr++; $display("[TB] FAIL sll31_latency got %0d want %0d", lat, ref_latency(4'b0011, 32'd31)); end
        do_op(4'b1000, 32'h8000_0000, 32'd1, r, z, il, lat);
        nvec++;
        if ({r, lat} !== {32'h4000_0000, 32'd1}) begin nerr++; $display("[TB] FAIL srl1 got %h lat=%0d want 40000000 lat=1", r, lat); end
        do_op(4'b1000, 32'h8000_0000, 32'd31, r, z, il, lat);
        nvec++;
        if ({r, z} !== {32'h1, 1'b0}) begin nerr++; $display("[TB] FAIL srl31 got %h z=%b want 1 z=0", r, z); end
    endtask

    task automatic test_slt_illegal;
        logic [XLEN-1:0] r; logic z, il; int lat;
        do_op(4'b0100, 32'hFFFF_FFFF, 32'h1, r, z, il, lat);
        nvec++;
        if (r !== 32'h1) begin nerr++; $display("[TB] FAIL slt got %h want 1", r); end
        do_op(4'b0101, 32'hFFFF_FFFF, 32'h1, r, z, il, lat);
        nvec++;
        if ({r, z} !== {32'h0, 1'b1}) begin nerr++; $display("[TB] FAIL sltu got %h z=%b want 0 z=1", r, z); end
        do_op(4'b1111, 32'hDEAD_BEEF, 32'h1234, r, z, il, lat);
        nvec++;
        if ({r, z, il, lat} !== {32'h0, 1'b1, 1'b1, 32'd1}) begin
            nerr++; $display("[TB] FAIL illegal got %h z=%b il=%b lat=%0d want 0 z=1 il=1 lat=1", r, z, il, lat);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        alu_ctrl = 4'b0111; op_a = 32'hF0F0; op_b = 32'h0FF0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'hFF00}) begin
                nerr++; $display("[TB] FAIL backpressure_hold[%0d] got v=%b rdy=%b res=%h want 1/0/0000ff00", i, out_valid, in_ready, result);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        nvec++;
        if ({in_ready, out_valid} !== 2'b10) begin nerr++; $display("[TB] FAIL release_idle got rdy=%b v=%b want 1/0", in_ready, out_valid); end
        alu_ctrl = 4'b0001; op_a = 32'h00F0; op_b = 32'h000F; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        nvec++;
        if ({out_valid, result} !== {1'b1, 32'h00FF}) begin nerr++; $display("[TB] FAIL next_accept got v=%b res=%h want 1/000000ff", out_valid, result); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        bit seen;
        @(negedge clk);
        alu_ctrl = 4'b0011; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({out_valid, result} !== {1'b0, 32'h0}) begin nerr++; $display("[TB] FAIL midshift_reset got v=%b res=%h want 0/0", out_valid, result); end
        rst_n = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL midshift_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin nerr++; $display("[TB] FAIL midshift_discarded got completion want none"); end
    endtask

    task automatic test_random;
        logic [XLEN-1:0] r, a, b; logic z, il; logic [3:0] c; int lat;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 5 == 0) a = b;
            do_op(c, a, b, r, z, il, lat);
            nvec++;
            if ({r, z, il} !== {ref_result(c, a, b), (ref_result(c, a, b) == 0), ref_illegal(c)}) begin
                nerr++;
                $display("[TB] FAIL random[%0d] ctrl=%b a=%h b=%h got %h z=%b il=%b want %h z=%b il=%b",
                         i, c, a, b, r, z, il, ref_result(c, a, b), (ref_result(c, a, b) == 0), ref_illegal(c));
            end
            nvec++;
            if (lat !== ref_latency(c, b)) begin
                nerr++; $display("[TB] FAIL random_latency[%0d] ctrl=%b b=%h got %0d want %0d", i, c, b, lat, ref_latency(c, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shifts();
        test_slt_illegal();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
